// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_pkg
// Description : Shared types, opcodes and length helpers for spi_flash_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

    typedef enum logic [1:0] {
        CMD_READ    = 2'd0,
        CMD_PROGRAM = 2'd1,
        CMD_ERASE   = 2'd2,
        CMD_READ_ID = 2'd3
    } cmd_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WREN = 3'd1,
        ST_XFER = 3'd2,
        ST_POLL = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    localparam logic [7:0] C_OP_WREN    = 8'h06;
    localparam logic [7:0] C_OP_RDSR    = 8'h05;
    localparam logic [7:0] C_OP_READ    = 8'h03;
    localparam logic [7:0] C_OP_PROGRAM = 8'h02;
    localparam logic [7:0] C_OP_ERASE   = 8'h20;
    localparam logic [7:0] C_OP_READ_ID = 8'h9F;

    // Header bytes on the wire (opcode + address, or opcode alone)
    localparam logic [2:0]  C_HDR_ADDR = 3'd4;
    localparam logic [2:0]  C_HDR_ID   = 3'd1;

    localparam logic [15:0] C_LEN_WREN = 16'd8;
    localparam logic [15:0] C_LEN_RDSR = 16'd16;
    localparam logic [15:0] C_LEN_HDR  = 16'd32;

    function automatic logic [8:0] payload_bytes(input logic [8:0] n);
        return (n == 9'd0) ? 9'd256 : n;
    endfunction

    // Write-type commands need WREN and are sent with op=1
    function automatic logic xfer_op(input cmd_code_e code);
        return (code == CMD_PROGRAM) || (code == CMD_ERASE);
    endfunction

    function automatic logic [15:0] xfer_len(input cmd_code_e code, input logic [8:0] n);
        if ((code == CMD_READ) || (code == CMD_PROGRAM))
            return C_LEN_HDR + {4'd0, payload_bytes(n), 3'd0};
        return C_LEN_HDR;
    endfunction

    function automatic logic [7:0] opcode_of(input cmd_code_e code);
        case (code)
            CMD_READ:    return C_OP_READ;
            CMD_PROGRAM: return C_OP_PROGRAM;
            CMD_ERASE:   return C_OP_ERASE;
            default:     return C_OP_READ_ID;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_ctrl_if
// Description : Host command/data bus plus spi_interface handshake signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_code;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_nbytes;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        work;
    logic        op;
    logic [15:0] len;
    logic [7:0]  rdata;
    logic        spi_byte_req;
    logic        spi_rx_valid;
    logic [7:0]  spi_rx_byte;
    logic        spi_done;

    modport slave (
        input  cmd_valid, cmd_code, cmd_addr, cmd_nbytes, wr_data, wr_valid,
               spi_byte_req, spi_rx_valid, spi_rx_byte, spi_done,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
               work, op, len, rdata
    );

    modport master (
        output cmd_valid, cmd_code, cmd_addr, cmd_nbytes, wr_data, wr_valid,
               spi_byte_req, spi_rx_valid, spi_rx_byte, spi_done,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
               work, op, len, rdata
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_byte_mux.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_byte_mux
// Description : Selects the byte presented to spi_interface for the current
//               state and byte index.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_byte_mux
    import spi_flash_pkg::*;
(
    input  state_e      i_state,
    input  cmd_code_e   i_code,
    input  logic [8:0]  i_idx,
    input  logic [23:0] i_addr,
    input  logic [7:0]  i_payload,
    output logic [7:0]  o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_state)
            ST_WREN: o_byte = C_OP_WREN;
            ST_POLL: begin
                if (i_idx == 9'd0)
                    o_byte = C_OP_RDSR;
            end
            ST_XFER: begin
                if (i_idx == 9'd0)
                    o_byte = opcode_of(i_code);
                else if (i_code != CMD_READ_ID) begin
                    if (i_idx == 9'd1)
                        o_byte = i_addr[23:16];
                    else if (i_idx == 9'd2)
                        o_byte = i_addr[15:8];
                    else if (i_idx == 9'd3)
                        o_byte = i_addr[7:0];
                    else if (i_code == CMD_PROGRAM)
                        o_byte = i_payload;
                end
            end
            default: o_byte = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/spi_flash_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_ctrl
// Description : Flash command sequencer (WREN, command transfer, RDSR polling)
//               in front of spi_interface. Optional poll timeout is enabled by
//               defining SPI_FLASH_CTRL_POLL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_ctrl
    import spi_flash_pkg::*;
`ifdef SPI_FLASH_CTRL_POLL_TIMEOUT_EN
#(
    parameter int unsigned POLL_MAX = 65535
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    spi_flash_ctrl_if.slave bus
);

    state_e      r_state,  w_state_nxt;
    cmd_code_e   r_code,   w_code_nxt;
    logic [23:0] r_addr,   w_addr_nxt;
    logic [8:0]  r_nbytes, w_nbytes_nxt;
    logic [8:0]  r_idx,    w_idx_nxt;
    logic [2:0]  r_rx_cnt, w_rx_cnt_nxt;
    logic [7:0]  r_pay,    w_pay_nxt;
    logic        r_wip,    w_wip;
    logic        r_work,   w_work_nxt;
    logic        r_op,     w_op_nxt;
    logic [15:0] r_len,    w_len_nxt;
    logic        r_err,    w_err_nxt;
`ifdef SPI_FLASH_CTRL_POLL_TIMEOUT_EN
    logic [15:0] r_poll_cnt, w_poll_cnt_nxt;
`endif

    cmd_code_e   w_cmd_code;
    logic        w_cmd_ready;
    logic        w_accept;
    logic        w_active;
    logic        w_byte_adv;
    logic        w_pay_req;
    logic        w_rd_valid;
    logic [8:0]  w_idx_inc;
    logic [8:0]  w_n;
    logic [2:0]  w_rx_hdr;
    logic [7:0]  w_byte;

    assign w_cmd_code  = cmd_code_e'(bus.cmd_code);
    assign w_cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_active    = (r_state == ST_WREN) || (r_state == ST_XFER) || (r_state == ST_POLL);
    // A byte request coinciding with spi_done is past the end of the transfer
    assign w_byte_adv  = w_active && bus.spi_byte_req && !bus.spi_done;
    assign w_idx_inc   = r_idx + 9'd1;
    assign w_n         = payload_bytes(r_nbytes);
    assign w_pay_req   = w_byte_adv && (r_state == ST_XFER) && (r_code == CMD_PROGRAM) &&
                         (w_idx_inc >= {6'd0, C_HDR_ADDR}) &&
                         ({1'b0, w_idx_inc} < ({7'd0, C_HDR_ADDR} + {1'b0, w_n}));
    assign w_rx_hdr    = (r_code == CMD_READ_ID) ? C_HDR_ID : C_HDR_ADDR;
    assign w_rd_valid  = bus.spi_rx_valid && (r_state == ST_XFER) && !xfer_op(r_code) &&
                         (r_rx_cnt >= w_rx_hdr);
    // WIP is bit0 of the second byte received during RDSR
    assign w_wip       = (bus.spi_rx_valid && (r_state == ST_POLL) && (r_rx_cnt == 3'd1)) ?
                         bus.spi_rx_byte[0] : r_wip;

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_addr_nxt   = r_addr;
        w_nbytes_nxt = r_nbytes;
        w_idx_nxt    = r_idx;
        w_rx_cnt_nxt = r_rx_cnt;
        w_pay_nxt    = r_pay;
        w_work_nxt   = 1'b0;
        w_op_nxt     = r_op;
        w_len_nxt    = r_len;
        w_err_nxt    = r_err;
`ifdef SPI_FLASH_CTRL_POLL_TIMEOUT_EN
        w_poll_cnt_nxt = r_poll_cnt;
`endif

        if (w_byte_adv)
            w_idx_nxt = w_idx_inc;
        if (w_active && bus.spi_rx_valid && (r_rx_cnt != 3'd7))
            w_rx_cnt_nxt = r_rx_cnt + 3'd1;
        if (w_pay_req) begin
            if (bus.wr_valid) begin
                w_pay_nxt = bus.wr_data;
            end else begin
                w_pay_nxt = 8'hFF;
                w_err_nxt = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_code_nxt   = w_cmd_code;
                    w_addr_nxt   = bus.cmd_addr;
                    w_nbytes_nxt = bus.cmd_nbytes;
                    w_err_nxt    = 1'b0;
                    w_idx_nxt    = 9'd0;
                    w_rx_cnt_nxt = 3'd0;
                    w_work_nxt   = 1'b1;
                    if (xfer_op(w_cmd_code)) begin
                        w_state_nxt = ST_WREN;
                        w_op_nxt    = 1'b1;
                        w_len_nxt   = C_LEN_WREN;
                    end else begin
                        w_state_nxt = ST_XFER;
                        w_op_nxt    = 1'b0;
                        w_len_nxt   = xfer_len(w_cmd_code, bus.cmd_nbytes);
                    end
                end
            end
            ST_WREN: begin
                if (bus.spi_done) begin
                    w_state_nxt  = ST_XFER;
                    w_work_nxt   = 1'b1;
                    w_op_nxt     = xfer_op(r_code);
                    w_len_nxt    = xfer_len(r_code, r_nbytes);
                    w_idx_nxt    = 9'd0;
                    w_rx_cnt_nxt = 3'd0;
                end
            end
            ST_XFER: begin
                if (bus.spi_done) begin
                    if (xfer_op(r_code)) begin
                        w_state_nxt  = ST_POLL;
                        w_work_nxt   = 1'b1;
                        w_op_nxt     = 1'b0;
                        w_len_nxt    = C_LEN_RDSR;
                        w_idx_nxt    = 9'd0;
                        w_rx_cnt_nxt = 3'd0;
`ifdef SPI_FLASH_CTRL_POLL_TIMEOUT_EN
                        w_poll_cnt_nxt = 16'd0;
`endif
                    end else begin
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_POLL: begin
                if (bus.spi_done) begin
                    if (w_wip) begin
`ifdef SPI_FLASH_CTRL_POLL_TIMEOUT_EN
                        if ((32'(r_poll_cnt) + 32'd1) >= POLL_MAX) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_FIN;
                        end else begin
                            w_poll_cnt_nxt = r_poll_cnt + 16'd1;
                            w_work_nxt     = 1'b1;
                            w_idx_nxt      = 9'd0;
                            w_rx_cnt_nxt   = 3'd0;
                        end
`else
                        w_work_nxt   = 1'b1;
                        w_idx_nxt    = 9'd0;
                        w_rx_cnt_nxt = 3'd0;
`endif
                    end else begin
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_code   <= CMD_READ;
            r_addr   <= 24'd0;
            r_nbytes <= 9'd0;
            r_idx    <= 9'd0;
            r_rx_cnt <= 3'd0;
            r_pay    <= 8'd0;
            r_wip    <= 1'b0;
            r_work   <= 1'b0;
            r_op     <= 1'b0;
            r_len    <= 16'd0;
            r_err    <= 1'b0;
`ifdef SPI_FLASH_CTRL_POLL_TIMEOUT_EN
            r_poll_cnt <= 16'd0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_addr   <= w_addr_nxt;
            r_nbytes <= w_nbytes_nxt;
            r_idx    <= w_idx_nxt;
            r_rx_cnt <= w_rx_cnt_nxt;
            r_pay    <= w_pay_nxt;
            r_wip    <= w_wip;
            r_work   <= w_work_nxt;
            r_op     <= w_op_nxt;
            r_len    <= w_len_nxt;
            r_err    <= w_err_nxt;
`ifdef SPI_FLASH_CTRL_POLL_TIMEOUT_EN
            r_poll_cnt <= w_poll_cnt_nxt;
`endif
        end
    end

    spi_flash_byte_mux u_byte_mux (
        .i_state   (r_state),
        .i_code    (r_code),
        .i_idx     (r_idx),
        .i_addr    (r_addr),
        .i_payload (r_pay),
        .o_byte    (w_byte)
    );

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.wr_ready  = w_pay_req;
    assign bus.rd_valid  = w_rd_valid;
    assign bus.rd_data   = w_rd_valid ? bus.spi_rx_byte : 8'h00;
    assign bus.done      = (r_state == ST_FIN);
    assign bus.err       = r_err;
    assign bus.work      = r_work;
    assign bus.op        = r_op;
    assign bus.len       = r_len;
    assign bus.rdata     = w_byte;

endmodule
`default_nettype wire

// File: doc/spi_flash_ctrl.md
# spi_flash_ctrl

Command sequencer in front of `spi_interface`. It turns host-level flash commands (READ, PROGRAM, ERASE_SECTOR, READ_ID) into the transfers `spi_interface` executes: it drives `work`/`op`/`len`/`rdata` and inserts WREN before write-type commands. It then polls the status register until the flash clears WIP. It sits between the JTAG register bridge and `spi_interface`.

## Interface
- `POLL_MAX`, default 65535: maximum RDSR polls before a timeout error (timeout feature only).
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_code`  in  2  0 READ, 1 PROGRAM, 2 ERASE_SECTOR, 3 READ_ID.
- `cmd_addr`  in  24  flash byte address.
- `cmd_nbytes`  in  9  data bytes, 1..256; ignored for ERASE and READ_ID.
- `wr_data` / `wr_valid` / `wr_ready`  in/in/out  8/1/1  PROGRAM payload stream.
- `rd_data` / `rd_valid`  out  8/1  READ and READ_ID payload; no backpressure.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  sticky; set on underrun or timeout; cleared on next accept.
- `work`  out  1  one-cycle start pulse to `spi_interface`.
- `op`  out  1  1 = write-only transfer, 0 = transfer with MISO capture.
- `len`  out  16  transfer length in bits.
- `rdata`  out  8  byte presented for shifting out.
- `spi_byte_req`  in  1  `spi_interface` has latched `rdata`; next byte is due the following cycle.
- `spi_rx_valid` / `spi_rx_byte`  in  1/8  captured MISO byte, one per shifted byte when `op`=0.
- `spi_done`  in  1  pulse at the end of a transfer.

## Operation
- FSM states: IDLE, WREN, XFER, POLL, FIN.
- IDLE:
  - `cmd_ready`=1; on accept, latch the command.
  - Go to WREN for PROGRAM and ERASE_SECTOR; otherwise go to XFER.
- WREN: transfer byte 0x06 with `op`=1, `len`=8. On `spi_done` go to XFER.
- XFER byte stream: opcode (READ 0x03, PROGRAM 0x02, ERASE 0x20, READ_ID 0x9F), then addr[23:16], addr[15:8], addr[7:0] (address bytes omitted for READ_ID), then payload.
  - READ: `op`=0, `len`=32+8·n.
  - PROGRAM: `op`=1, `len`=32+8·n.
  - ERASE: `op`=1, `len`=32.
  - READ_ID: `op`=0, `len`=32.
- Byte index advances on `spi_byte_req`; `rdata` = byte[index].
- PROGRAM payload:
  - `wr_ready` is pulsed together with the `spi_byte_req` that needs a payload byte.
  - If `wr_valid`=0 at that moment, set `err`, send 0xFF and continue (the transfer is never aborted).
- RX handling: the first 4 rx bytes (READ) or the first 1 (READ_ID) are header echo and are discarded. Later rx bytes go to `rd_data`/`rd_valid` in the same cycle.
- On `spi_done`: PROGRAM/ERASE go to POLL; READ/READ_ID go to FIN.
- POLL:
  - Issue RDSR: 0x05 then dummy 0x00, `op`=0, `len`=16.
  - The second rx byte bit0 is WIP. WIP=1 means re-issue RDSR; WIP=0 means go to FIN.
- FIN: `done`=1 for one cycle, then IDLE.

## Timing
- Reset: `cmd_ready`=0 during `rst`, 1 the first cycle after.
- All other outputs reset to 0; FSM resets to IDLE.
- `work` asserts exactly one cycle after accept (or after `spi_done` for chained transfers). `len`/`op`/`rdata` are valid in that same cycle and held until `spi_done`.
- No `work` is issued while a transfer is outstanding.
- `rst` mid-transfer returns to IDLE immediately; `spi_interface` is reset by the same `rst`.
- `cmd_valid` while not in IDLE: held off (`cmd_ready`=0).
- `cmd_nbytes`=0 is treated as 256. The `len` arithmetic is done in 16 bits: maximum 32+2048 = 2080, no overflow.
- `spi_byte_req` and `spi_done` in the same cycle: the byte request is ignored (index is past the end).

## Configuration
- `SPI_FLASH_CTRL_POLL_TIMEOUT_EN` defined:
  - A 16-bit poll counter runs in POLL.
  - After `POLL_MAX` polls with WIP=1: set `err`, go to FIN.
- Not defined: no counter; POLL loops until WIP=0.

## Structure
- Package `spi_flash_pkg` holds:
  - the `cmd_code` enum;
  - the FSM state enum;
  - opcode localparams (0x06, 0x05, 0x03, 0x02, 0x20, 0x9F);
  - the header length constants.
- Sub-module `spi_flash_byte_mux`: combinational selection of `rdata` from index, state, command, address and payload. The FSM and counters stay in the top.

## Test plan
- READ addr 0x123456, n=2, MISO bytes 0xA5, 0x5A after the header:
  - `work` with `op`=0, `len`=48;
  - `rdata` sequence 0x03, 0x12, 0x34, 0x56;
  - `rd_data` 0xA5 then 0x5A, then `done`.
- PROGRAM addr 0x000100, n=1, `wr_data`=0x67:
  - WREN (`len`=8, 0x06);
  - then `len`=40 with bytes 0x02, 0x00, 0x01, 0x00, 0x67;
  - then RDSR returns 0x01, 0x01, 0x00 → three polls, then `done`, `err`=0.
- ERASE with `wr_valid` irrelevant: WREN, then `len`=32 (0x20+addr), POLL; WIP=0 on the first poll → `done`.
- PROGRAM n=2 with `wr_valid` low on the second payload request → 0xFF sent, `err`=1, `done` still pulses.
- With `SPI_FLASH_CTRL_POLL_TIMEOUT_EN` and `POLL_MAX`=4, WIP stuck at 1 → exactly 4 RDSR transfers, `err`=1, `done`.
- `rst` asserted during an XFER payload → next cycle: IDLE, all outputs 0; a new READ_ID is accepted after release with `len`=32.
